uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between N_REQ independent producers, such as the sonar/servo telemetry path, command acknowledgements and status reports. Each producer presents a 2-byte frame. The block picks one producer round-robin, latches its frame and drives the UART byte handshake (tx_rdy / active-low data_wen / data) for both bytes. It then acknowledges the producer, so two producers' bytes are never interleaved on the serial line.

Parameters:
N_REQ, 3, number of requesters (2..8)
TIMEOUT, 1024, cycles to wait for tx_rdy to drop after a byte is written before aborting the frame
FRAME_W, 16, frame width; fixed at 2 bytes, exposed for slicing only

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester frame request; level, held until ack
frame  in  N_REQ*16  requester i owns bits [16*i+15:16*i]; [15:8] is sent first
ack  out  N_REQ  one-cycle pulse to the requester whose frame completed
busy  out  1  high from grant until return to IDLE
tx_rdy  in  1  UART transmitter idle / ready for a byte
data_wen  out  1  active-low write strobe to the UART, low for exactly one cycle per byte
data  out  8  byte to the UART, valid while data_wen is low
timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: data_wen=1, data=0, ack=0, busy=0, timeout_err=0, rr pointer=0, state=IDLE, timeout counter=0.
- States: IDLE, WAIT_RDY_0, SEND_0, WAIT_RDY_1, SEND_1, DONE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the index and the 16-bit frame, set busy=1, go to WAIT_RDY_0.
  - Later changes to req or frame are ignored.
- WAIT_RDY_0: when tx_rdy=1, set data<=frame[15:8] and data_wen<=0, clear the counter, go to SEND_0.
- SEND_0:
  - data_wen<=1, so the strobe is exactly one cycle.
  - When tx_rdy=0, go to WAIT_RDY_1.
  - Otherwise count up. At TIMEOUT-1, pulse timeout_err, skip ack, advance the pointer and go to IDLE.
- WAIT_RDY_1 / SEND_1: identical to WAIT_RDY_0 / SEND_0 using frame[7:0]. SEND_1 exits to DONE.
- DONE:
  - Pulse ack[idx] for one cycle, set busy=0.
  - Pointer <= idx+1, wrapping from N_REQ-1 to 0. Go to IDLE.
- Latency: req high in cycle 0 with tx_rdy already high gives data_wen low in cycle 2. Minimum frame duration is 7 cycles plus UART time.
- Re-arbitration: the earliest is the cycle after DONE. A requester must drop or refresh req in the cycle it sees ack, otherwise it is re-granted only after the others, never back-to-back while another req is pending.
- Simultaneous requests: grant the lowest index at or after the pointer; the others wait. Any requester waits at most N_REQ-1 frames.
- req dropped mid-frame: the frame still completes and ack is still pulsed.
- Timeout: the aborted requester gets no ack; it keeps req and retries after the others have had a turn.
- Reset mid-frame: return to IDLE immediately, data_wen=1. A partially sent frame is not resumed.
- The counter is clog2(TIMEOUT) bits and saturates; it never wraps.

Decomposition:
- Shared package holds the state encoding constants, FRAME_W=16, and byte-order constants (HI first).
- One sub-module, rr_pick: combinational round-robin selector taking req and pointer, producing a one-hot grant and a valid bit. The FSM, counter and latches stay in uart_tx_arbiter.

Test Plan:
- Single requester: req[0]=1, frame0=16'hA55A, tx_rdy model drops 2 cycles after the strobe and rises after 20 cycles. Required: data 8'hA5 then 8'h5A, each strobe one cycle wide, ack[0] pulses once, busy returns to 0.
- Simultaneous requests: req=3'b011 with pointer 0, frame0=16'h1122, frame1=16'h3344. Required byte order 11,22,33,44; ack[0] then ack[1].
- Fairness: req=3'b111 held high and re-asserted after each ack, for 9 frames. Required grant order 0,1,2,0,1,2,0,1,2.
- Timeout: tx_rdy stuck at 1 after the first strobe, TIMEOUT=16. Required: timeout_err pulses 16 cycles after SEND_0 entry, no ack, busy drops, requester 0 retried after any pending others.
- Request dropped mid-frame: req[2] falls during WAIT_RDY_1. Required: the second byte is still sent and ack[2] is pulsed.
- Reset mid-frame: assert rst_n=0 during SEND_1. Required: data_wen=1, busy=0, ack=0 asynchronously. After release, a fresh req[1] is granted first (pointer=0, only req[1] set).

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter:
//   FRAME_W / BYTE_W  - frame and byte widths (a frame is always two bytes)
//   FIRST_BYTE / SECOND_BYTE - byte order on the wire (high byte first)
//   state_t           - arbiter FSM encoding
//   frame_byte()      - pick one byte out of a latched frame
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

   localparam int FRAME_W = 16;
   localparam int BYTE_W  = 8;

   localparam logic BYTE_HI     = 1'b1;
   localparam logic BYTE_LO     = 1'b0;
   localparam logic FIRST_BYTE  = BYTE_HI;
   localparam logic SECOND_BYTE = BYTE_LO;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY_0,
      SEND_0,
      WAIT_RDY_1,
      SEND_1,
      DONE
   } state_t;

   function automatic logic [BYTE_W-1:0] frame_byte(input logic [FRAME_W-1:0] f,
                                                    input logic              sel);
      return sel ? f[FRAME_W-1:BYTE_W] : f[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the producer side (req/frame/ack) and the UART byte handshake
// (tx_rdy/data_wen/data) plus status (busy/timeout_err).
//   master : the arbiter (drives ack, busy, data_wen, data, timeout_err)
//   slave  : producers + UART (drive req, frame, tx_rdy)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]         req;
   logic [N_REQ*FRAME_W-1:0] frame;
   logic [N_REQ-1:0]         ack;
   logic                     busy;
   logic                     tx_rdy;
   logic                     data_wen;
   logic [BYTE_W-1:0]        data;
   logic                     timeout_err;

   modport master (
      input  req, frame, tx_rdy,
      output ack, busy, data_wen, data, timeout_err
   );

   modport slave (
      output req, frame, tx_rdy,
      input  ack, busy, data_wen, data, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick
// Combinational round-robin selector: grants the first set request at or
// after the pointer, wrapping modulo N_REQ.
//   i_req   - request vector
//   i_ptr   - index with highest priority this round
//   o_grant - one-hot grant (all zero when nothing requested)
//   o_valid - at least one request present
// ---------------------------------------------------------------------------
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic             o_valid
);
   logic [PTR_W-1:0] w_k;

   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_k     = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         w_k = PTR_W'((32'(i_ptr) + off) % N_REQ);
         if (!o_valid && i_req[w_k]) begin
            o_grant[w_k] = 1'b1;
            o_valid      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ producers. A producer is picked
// round-robin, its 2-byte frame is latched and sent high byte first over the
// tx_rdy / data_wen (active low) / data handshake, then the producer gets a
// one-cycle ack. If tx_rdy never drops after a strobe within TIMEOUT cycles
// the frame is aborted with a timeout_err pulse and no ack.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - uart_tx_arbiter_if.master (req, frame, ack, busy, tx_rdy,
//                data_wen, data, timeout_err)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 1024,
   parameter int FRAME_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arbiter_if.master  bus
);
   localparam int PTR_W = (N_REQ > 1)   ? $clog2(N_REQ)   : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             r_state, w_state_nxt;
   logic [PTR_W-1:0]   r_idx, w_idx_nxt;
   logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
   logic [FRAME_W-1:0] r_frame, w_frame_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_wen, w_wen_nxt;
   logic [BYTE_W-1:0]  r_data, w_data_nxt;
   logic [N_REQ-1:0]   r_ack, w_ack_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_terr, w_terr_nxt;

   logic [N_REQ-1:0]   w_grant;
   logic               w_valid;
   logic [PTR_W-1:0]   w_gidx;
   logic [FRAME_W-1:0] w_gframe;
   logic [PTR_W-1:0]   w_ptr_inc;
   logic [CNT_W-1:0]   w_cnt_inc;

   uart_tx_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_valid (w_valid)
   );

   // one-hot grant -> index and the granted producer's frame
   always_comb begin
      w_gidx   = '0;
      w_gframe = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_gidx   = PTR_W'(i);
            w_gframe = bus.frame[FRAME_W*i +: FRAME_W];
         end
      end
   end

   assign w_ptr_inc = (r_idx == PTR_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_frame_nxt = r_frame;
      w_cnt_nxt   = r_cnt;
      w_wen_nxt   = 1'b1;
      w_data_nxt  = r_data;
      w_ack_nxt   = '0;
      w_busy_nxt  = r_busy;
      w_terr_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_idx_nxt   = w_gidx;
               w_frame_nxt = w_gframe;
               w_busy_nxt  = 1'b1;
               w_state_nxt = WAIT_RDY_0;
            end
         end
         WAIT_RDY_0: begin
            if (bus.tx_rdy) begin
               w_data_nxt  = frame_byte(r_frame, FIRST_BYTE);
               w_wen_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = SEND_0;
            end
         end
         SEND_0: begin
            if (!bus.tx_rdy) begin
               w_state_nxt = WAIT_RDY_1;
            end else if (r_cnt == CNT_LAST) begin
               // abort: no ack, and the aborted producer loses its turn
               w_terr_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_ptr_nxt   = w_ptr_inc;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         WAIT_RDY_1: begin
            if (bus.tx_rdy) begin
               w_data_nxt  = frame_byte(r_frame, SECOND_BYTE);
               w_wen_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = SEND_1;
            end
         end
         SEND_1: begin
            if (!bus.tx_rdy) begin
               w_state_nxt = DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_terr_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_ptr_nxt   = w_ptr_inc;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         DONE: begin
            w_ack_nxt[r_idx] = 1'b1;
            w_busy_nxt       = 1'b0;
            w_ptr_nxt        = w_ptr_inc;
            w_state_nxt      = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_frame <= '0;
         r_cnt   <= '0;
         r_wen   <= 1'b1;
         r_data  <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_terr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_frame <= w_frame_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wen   <= w_wen_nxt;
         r_data  <= w_data_nxt;
         r_ack   <= w_ack_nxt;
         r_busy  <= w_busy_nxt;
         r_terr  <= w_terr_nxt;
      end
   end

   assign bus.ack         = r_ack;
   assign bus.busy        = r_busy;
   assign bus.data_wen    = r_wen;
   assign bus.data        = r_data;
   assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=3, TIMEOUT=16). A UART model
// drops tx_rdy 2 cycles after each strobe and raises it 20 cycles later.
// Expected bytes and acks are queued when a test is set up and popped by a
// monitor as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   localparam int N  = 3;
   localparam int TO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(
      .N_REQ   (N),
      .TIMEOUT (TO),
      .FRAME_W (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_cmp  = 0;
   int unsigned n_bad  = 0;
   int unsigned n_terr = 0;
   bit          stuck  = 1'b0;
   logic [7:0]  exp_bytes[$];
   int unsigned exp_acks[$];

   // order: grant j is in nibble j (lowest nibble = first grant)
   typedef struct {
      logic [2:0]  req;
      logic [47:0] frames;
      int unsigned n;
      bit          hold;
      logic [35:0] order;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic expect_frame(input int unsigned idx, input logic [15:0] f);
      exp_bytes.push_back(f[15:8]);
      exp_bytes.push_back(f[7:0]);
      exp_acks.push_back(idx);
   endtask

   // UART model
   initial begin
      int unsigned drop_cd;
      int unsigned rise_cd;
      drop_cd    = 0;
      rise_cd    = 0;
      bus.tx_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (!bus.data_wen) begin
            if (!stuck) drop_cd = 2;
         end else if (drop_cd != 0) begin
            drop_cd--;
            if (drop_cd == 0) begin
               bus.tx_rdy = 1'b0;
               rise_cd    = 20;
            end
         end else if (rise_cd != 0) begin
            rise_cd--;
            if (rise_cd == 0) bus.tx_rdy = 1'b1;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic        prev_wen;
      int unsigned e;
      prev_wen = 1'b1;
      forever begin
         @(negedge clk);
         if (!bus.data_wen) begin
            check("strobe_width", 32'(prev_wen), 1);
            if (exp_bytes.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_byte: got %0h, want none", bus.data);
            end else begin
               check("byte", 32'(bus.data), 32'(exp_bytes.pop_front()));
            end
         end
         if (bus.ack != '0) begin
            if (exp_acks.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: got %0h, want none", bus.ack);
            end else begin
               e = exp_acks.pop_front();
               check("ack", 32'(bus.ack), 32'(1) << e);
            end
         end
         if (bus.timeout_err) n_terr++;
         prev_wen = bus.data_wen;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      bus.req = '0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_uart_idle();
      int unsigned c = 0;
      while (!bus.tx_rdy && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("uart_idle", 32'(bus.tx_rdy), 1);
   endtask

   task automatic wait_strobe(input string name);
      int unsigned c = 0;
      while (bus.data_wen && c < 100) begin
         @(negedge clk);
         c++;
      end
      check(name, 32'(bus.data_wen), 0);
   endtask

   // runs until n acks; producers drop their req on ack unless hold is set
   task automatic run_frames(input int unsigned n, input bit hold,
                             input int unsigned budget, output int first_strobe);
      int unsigned seen = 0;
      int unsigned cyc  = 0;
      first_strobe = -1;
      while (seen < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (!bus.data_wen && first_strobe < 0) begin
            first_strobe = int'(cyc);
            check("busy_active", 32'(bus.busy), 1);
         end
         if (bus.ack != '0) begin
            seen++;
            if (hold) begin
               if (seen == n) bus.req = '0;
            end else begin
               bus.req = bus.req & ~bus.ack;
            end
         end
      end
      check("frames_done", seen, n);
   endtask

   task automatic end_checks(input string name, input int unsigned terr0, input int unsigned terr_exp);
      repeat (2) @(negedge clk);
      check({name, "_busy_idle"}, 32'(bus.busy), 0);
      check({name, "_bytes_left"}, exp_bytes.size(), 0);
      check({name, "_acks_left"}, exp_acks.size(), 0);
      check({name, "_timeouts"}, n_terr - terr0, terr_exp);
      exp_bytes.delete();
      exp_acks.delete();
   endtask

   initial begin
      vec_t        vecs[6];
      int          fs;
      int unsigned t0;
      int unsigned idx;
      int unsigned c;
      int unsigned nst;

      bus.req   = '0;
      bus.frame = '0;
      repeat (3) @(negedge clk);
      check("rst_data_wen", 32'(bus.data_wen), 1);
      check("rst_data", 32'(bus.data), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_timeout_err", 32'(bus.timeout_err), 0);
      #1 rst_n = 1'b1;

      vecs[0] = '{req: 3'b001, frames: 48'h0000_0000_A55A, n: 1, hold: 1'b0, order: 36'h0};
      vecs[1] = '{req: 3'b011, frames: 48'h0000_3344_1122, n: 2, hold: 1'b0, order: 36'h10};
      vecs[2] = '{req: 3'b111, frames: 48'hCAFE_BEEF_0F0F, n: 3, hold: 1'b0, order: 36'h210};
      vecs[3] = '{req: 3'b110, frames: 48'h5566_7788_FFFF, n: 2, hold: 1'b0, order: 36'h21};
      vecs[4] = '{req: 3'b100, frames: 48'hBEEF_0000_0000, n: 1, hold: 1'b0, order: 36'h2};
      vecs[5] = '{req: 3'b111, frames: 48'hA1A2_B1B2_C1C2, n: 9, hold: 1'b1, order: 36'h210210210};

      for (int unsigned v = 0; v < 6; v++) begin
         wait_uart_idle();
         do_reset();
         t0 = n_terr;
         bus.frame = vecs[v].frames;
         for (int unsigned j = 0; j < vecs[v].n; j++) begin
            idx = 32'(vecs[v].order[4*j +: 4]);
            expect_frame(idx, vecs[v].frames[16*idx +: 16]);
         end
         bus.req = vecs[v].req;
         run_frames(vecs[v].n, vecs[v].hold, 1000, fs);
         check("latency", fs, 2);
         end_checks("vec", t0, 0);
      end

      // req[2] dropped while waiting for the second byte
      wait_uart_idle();
      do_reset();
      t0 = n_terr;
      bus.frame = {16'hC3D4, 32'h0};
      expect_frame(2, 16'hC3D4);
      bus.req = 3'b100;
      wait_strobe("drop_first_strobe");
      repeat (5) @(negedge clk);
      bus.req = '0;
      run_frames(1, 1'b0, 200, fs);
      end_checks("drop", t0, 0);

      // timeout on requester 0, then requester 2, then 0 retried
      wait_uart_idle();
      do_reset();
      t0 = n_terr;
      stuck = 1'b1;
      bus.frame = {16'h2468, 16'h0000, 16'h1357};
      exp_bytes.push_back(8'h13);
      expect_frame(2, 16'h2468);
      expect_frame(0, 16'h1357);
      bus.req = 3'b101;
      wait_strobe("timeout_first_strobe");
      c = 0;
      while (!bus.timeout_err && c < 40) begin
         @(negedge clk);
         c++;
      end
      check("timeout_delay", c, TO);
      check("timeout_busy", 32'(bus.busy), 0);
      check("timeout_no_ack", 32'(bus.ack), 0);
      stuck = 1'b0;
      run_frames(2, 1'b0, 300, fs);
      end_checks("timeout", t0, 1);

      // reset during SEND_1
      wait_uart_idle();
      do_reset();
      t0 = n_terr;
      bus.frame = {32'h0, 16'h7788};
      exp_bytes.push_back(8'h77);
      exp_bytes.push_back(8'h88);
      bus.req = 3'b001;
      nst = 0;
      c   = 0;
      while (nst < 2 && c < 100) begin
         @(negedge clk);
         c++;
         if (!bus.data_wen) nst++;
      end
      check("rst_mid_strobes", nst, 2);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_data_wen", 32'(bus.data_wen), 1);
      check("async_rst_busy", 32'(bus.busy), 0);
      check("async_rst_ack", 32'(bus.ack), 0);
      bus.req = '0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      bus.frame = {16'h0000, 16'h99AA, 16'h0000};
      expect_frame(1, 16'h99AA);
      bus.req = 3'b010;
      run_frames(1, 1'b0, 200, fs);
      end_checks("rst_mid", t0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
